// File: rtl/mem_bus_if.sv
// Request/response bus between the core's memory controller and the memory responder.
interface mem_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: word RAM, fixed wait latency, fault flagging,
// byte-lane stores committed on entry to RESP.
module mem_bus_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_bus_if.slave bus
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIM = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        accept, commit;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        op_write;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        fault;
    logic [AW-1:0] widx;
    logic [4:0]  sh;
    logic [3:0]  be;
    logic [31:0] wlane, rshift, rmask;

    // In IDLE the operation is taken straight from the bus so a zero-latency
    // access can commit on its acceptance edge.
    always_comb begin
        op_write = (state == IDLE) ? bus.req_write : lat_write;
        op_size  = (state == IDLE) ? bus.req_size  : lat_size;
        op_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
        op_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

        fault = (op_size == 2'b11)
              || (op_size == 2'b01 && op_addr[0])
              || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
              || ({1'b0, op_addr} >= ADDR_LIM);

        widx = op_addr[AW+1:2];
        sh   = {op_addr[1:0], 3'b000};
        be   = 4'b0000;
        rmask = 32'h0;
        case (op_size)
            2'b00:   begin be = 4'b0001 << op_addr[1:0]; rmask = 32'h0000_00ff; end
            2'b01:   begin be = 4'b0011 << op_addr[1:0]; rmask = 32'h0000_ffff; end
            2'b10:   begin be = 4'b1111;                 rmask = 32'hffff_ffff; end
            default: begin be = 4'b0000;                 rmask = 32'h0;         end
        endcase
        wlane  = op_wdata << sh;
        rshift = mem[widx] >> sh;
    end

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        accept         = 1'b0;
        commit         = 1'b0;
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        case (state)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                cnt_d   = 4'(LATENCY);
                if (LATENCY == 0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (cnt <= 4'd1) begin
                commit  = 1'b1;
                cnt_d   = 4'd0;
                state_d = RESP;
            end else begin
                cnt_d = cnt - 4'd1;
            end
            RESP: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                lat_write <= bus.req_write;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= fault;
                rdata_q <= (fault || op_write) ? 32'h0 : (rshift & rmask);
            end else if (state == RESP && bus.resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    // RAM is not reset; a store caught by reset before its commit edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomised and directed bench for mem_bus_responder against a byte-addressed memory model.
module tb_mem_bus_responder;
    localparam int DEPTH = 1024;
    localparam int LIMIT = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_bus_if bus ();
    mem_bus_if bus0 ();
    virtual mem_bus_if vb;

    logic [7:0] mdl [LIMIT];

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Byte-addressed reference: faults leave memory alone, loads zero-extend.
    function automatic void model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'(LIMIT));
        rd = 32'h0;
        if (!er) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) begin
                if (w) mdl[int'(a) + i] = d[8*i +: 8];
                else   rd[8*i +: 8] = mdl[int'(a) + i];
            end
        end
    endfunction

    task automatic xact(input bit use0, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        if (use0) vb = bus0; else vb = bus;
        n = 0;
        @(negedge clk);
        while (vb.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vb.req_valid = 1'b1; vb.req_write = w; vb.req_size = sz; vb.req_addr = a; vb.req_wdata = d;
        @(posedge clk); #1;
        vb.req_valid = 1'b0; vb.req_addr = $urandom; vb.req_wdata = $urandom;
        lat = 0;
        do begin @(negedge clk); lat++; end while (vb.resp_valid !== 1'b1 && lat < 40);
        rd = vb.resp_rdata;
        er = vb.resp_err;
        repeat (hold) @(negedge clk);
        vb.resp_ready = 1'b1;
        @(posedge clk); #1;
        vb.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_lat2 got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        checks++;
        if ({bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_lat0 got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                     bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, exp; logic er, eer; int lat;
        model(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, exp, eer);
        xact(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL store_word got lat=%0d err=%b rdata=%h want 3 0 0", lat, er, rd);
        end
        xact(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_word got lat=%0d err=%b rdata=%h want 3 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd, exp; logic er, eer; int lat;
        model(1'b1, 2'b00, 32'h13, 32'h000000AA, exp, eer);
        xact(1'b0, 1'b1, 2'b00, 32'h13, 32'h000000AA, 0, rd, er, lat);
        xact(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hAAADBEEF) begin
            failures++;
            $display("FAIL byte_merge got err=%b rdata=%h want 0 aaadbeef", er, rd);
        end
        xact(1'b0, 1'b0, 2'b00, 32'h13, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h000000AA) begin
            failures++;
            $display("FAIL byte_load got err=%b rdata=%h want 0 000000aa", er, rd);
        end
        xact(1'b0, 1'b0, 2'b01, 32'h12, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000AAAD) begin
            failures++;
            $display("FAIL half_load got err=%b rdata=%h want 0 0000aaad", er, rd);
        end
    endtask

    task automatic test_faults;
        logic [31:0] rd, exp; logic er, eer; int lat;
        model(1'b1, 2'b10, 32'h0, 32'h01020304, exp, eer);
        xact(1'b0, 1'b1, 2'b10, 32'h0, 32'h01020304, 0, rd, er, lat);
        xact(1'b0, 1'b0, 2'b01, 32'h11, 32'h0, 0, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_half got lat=%0d err=%b rdata=%h want 3 1 0", lat, er, rd);
        end
        xact(1'b0, 1'b1, 2'b10, 32'h12, 32'h11223344, 0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_word got err=%b rdata=%h want 1 0", er, rd);
        end
        xact(1'b0, 1'b1, 2'b10, 32'(LIMIT), 32'h55667788, 0, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            failures++;
            $display("FAIL out_of_range got err=%b want 1", er);
        end
        xact(1'b0, 1'b1, 2'b11, 32'h0, 32'hFFFFFFFF, 0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL size_reserved got err=%b rdata=%h want 1 0", er, rd);
        end
        xact(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hAAADBEEF) begin
            failures++;
            $display("FAIL fault_untouched_10 got err=%b rdata=%h want 0 aaadbeef", er, rd);
        end
        xact(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h01020304) begin
            failures++;
            $display("FAIL fault_untouched_0 got err=%b rdata=%h want 0 01020304", er, rd);
        end
        model(1'b1, 2'b10, 32'(LIMIT - 4), 32'hC0FFEE11, exp, eer);
        xact(1'b0, 1'b1, 2'b10, 32'(LIMIT - 4), 32'hC0FFEE11, 0, rd, er, lat);
        xact(1'b0, 1'b0, 2'b00, 32'(LIMIT - 1), 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h000000C0) begin
            failures++;
            $display("FAIL last_byte got err=%b rdata=%h want 0 000000c0", er, rd);
        end
    endtask

    task automatic test_stall;
        logic [31:0] rd, exp; logic er, eer; int n;
        model(1'b0, 2'b10, 32'h10, 32'h0, exp, eer);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.resp_valid !== 1'b1 && n < 40);
        checks++;
        if (n !== 3 || bus.resp_rdata !== exp || bus.resp_err !== eer) begin
            failures++;
            $display("FAIL stall_first got lat=%0d rdata=%h err=%b want 3 %h %b",
                     n, bus.resp_rdata, bus.resp_err, exp, eer);
        end
        // A competing store offered while busy must be ignored.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_wdata = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata} !== {1'b1, 1'b0, eer, exp}) begin
                failures++;
                $display("FAIL stall_hold%0d got vld=%b rdy=%b err=%b rdata=%h want 1 0 %b %h",
                         k, bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata, eer, exp);
            end
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall_release got rdy=%b vld=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
        xact(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, er, n);
        checks++;
        if (er !== 1'b0 || rd !== exp) begin
            failures++;
            $display("FAIL stall_ignored_req got err=%b rdata=%h want 0 %h", er, rd, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, exp; logic er, eer; int lat, n;
        model(1'b1, 2'b10, 32'h20, 32'h11111111, exp, eer);
        xact(1'b0, 1'b1, 2'b10, 32'h20, 32'h11111111, 0, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset_in_wait got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        rst = 1'b0;
        xact(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h11111111) begin
            failures++;
            $display("FAIL dropped_store got err=%b rdata=%h want 0 11111111", er, rd);
        end
        // Reset after the commit edge: the store has already landed.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h24; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.resp_valid !== 1'b1 && n < 40);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_resp got vld=%b rdy=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
        rst = 1'b0;
        model(1'b1, 2'b10, 32'h24, 32'hCAFEF00D, exp, eer);
        xact(1'b0, 1'b0, 2'b10, 32'h24, 32'h0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL committed_store got err=%b rdata=%h want 0 cafef00d", er, rd);
        end
    endtask

    task automatic test_lat0;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 1'b1, 2'b10, 32'h8, 32'hA5A5F00D, 0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL lat0_store got lat=%0d err=%b rdata=%h want 1 0 0", lat, er, rd);
        end
        xact(1'b1, 1'b0, 2'b00, 32'h9, 32'h0, 1, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h000000F0) begin
            failures++;
            $display("FAIL lat0_load got lat=%0d err=%b rdata=%h want 1 0 000000f0", lat, er, rd);
        end
        xact(1'b1, 1'b0, 2'b10, 32'h6, 32'h0, 0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL lat0_fault got lat=%0d err=%b rdata=%h want 1 1 0", lat, er, rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, exp, a, d; logic er, eer, w; logic [1:0] sz; int lat, r;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model(1'b1, 2'b10, 32'(4 * i), d, exp, eer);
            xact(1'b0, 1'b1, 2'b10, 32'(4 * i), d, 0, rd, er, lat);
        end
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            a = ($urandom_range(0, 9) == 0) ? 32'(LIMIT + $urandom_range(0, 63)) : 32'($urandom_range(0, 63));
            d = $urandom;
            model(w, sz, a, d, exp, eer);
            xact(1'b0, w, sz, a, d, $urandom_range(0, 2), rd, er, lat);
            checks++;
            if (lat !== 3 || er !== eer || rd !== exp) begin
                failures++;
                $display("FAIL rand%0d w=%b sz=%b a=%h got lat=%0d err=%b rdata=%h want 3 %b %h",
                         i, w, sz, a, lat, er, rd, eer, exp);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_size = 2'b00;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0; bus0.resp_ready = 1'b0;
        test_reset;
        test_store_load;
        test_byte_lanes;
        test_faults;
        test_stall;
        test_reset_mid;
        test_lat0;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
